// File: rtl/nor3_tt_sequencer.sv
// Exhaustive truth-table sequencer for a 3-input NOR gate under test.
// Optional first-failure capture is enabled by defining NOR3_TT_FIRSTFAIL_EN.
module nor3_tt_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] result_mask,
    output logic [3:0] fail_count
`ifdef NOR3_TT_FIRSTFAIL_EN
    ,
    output logic [2:0] first_fail,
    output logic       first_fail_vld
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    function automatic logic nor3_exp(input logic [2:0] v);
        return ~(v[2] | v[1] | v[0]);
    endfunction

    state_t     state_r, state_s;
    logic [2:0] vec_r, vec_s;
    logic [3:0] cnt_r, cnt_s;
    logic [2:0] drive_r, drive_s;
    logic       done_r, done_s;
    logic       pass_r, pass_s;
    logic [7:0] mask_r, mask_s;
    logic [3:0] fcnt_r, fcnt_s;
    logic [2:0] ff_r, ff_s;
    logic       ffv_r, ffv_s;
    logic       match_s;

    // Next-state, next-drive and result update logic.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        cnt_s   = cnt_r;
        drive_s = 3'd0;
        done_s  = 1'b0;
        pass_s  = pass_r;
        mask_s  = mask_r;
        fcnt_s  = fcnt_r;
        ff_s    = ff_r;
        ffv_s   = ffv_r;
        match_s = (dut_y == nor3_exp(drive_r));
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_s = SETTLE;
                    vec_s   = 3'd0;
                    cnt_s   = SETTLE_LD;
                    mask_s  = 8'h00;
                    fcnt_s  = 4'd0;
                    pass_s  = 1'b0;
                    ff_s    = 3'd0;
                    ffv_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_s = IDLE;
                    mask_s  = 8'h00;
                    fcnt_s  = 4'd0;
                    pass_s  = 1'b0;
                    ff_s    = 3'd0;
                    ffv_s   = 1'b0;
                end else begin
                    drive_s = vec_r;
                    cnt_s   = cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_s = SAMPLE;
                    end else begin
                        state_s = SETTLE;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_s = IDLE;
                    mask_s  = 8'h00;
                    fcnt_s  = 4'd0;
                    pass_s  = 1'b0;
                    ff_s    = 3'd0;
                    ffv_s   = 1'b0;
                end else begin
                    mask_s[vec_r] = match_s;
                    if (!match_s) begin
                        fcnt_s = fcnt_r + 4'd1;
                        if (!ffv_r) begin
                            ff_s  = vec_r;
                            ffv_s = 1'b1;
                        end else begin
                            ff_s  = ff_r;
                        end
                    end else begin
                        fcnt_s = fcnt_r;
                    end
                    // pass must already reflect the last vector while done is high
                    if (vec_r == 3'd7) begin
                        state_s = DONE;
                        done_s  = 1'b1;
                        pass_s  = (fcnt_s == 4'd0);
                    end else begin
                        state_s = SETTLE;
                        vec_s   = vec_r + 3'd1;
                        cnt_s   = SETTLE_LD;
                        drive_s = vec_r + 3'd1;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
                if (abort) begin
                    mask_s = 8'h00;
                    fcnt_s = 4'd0;
                    pass_s = 1'b0;
                    ff_s   = 3'd0;
                    ffv_s  = 1'b0;
                end else begin
                    mask_s = mask_r;
                end
            end
            default: begin
                state_s = IDLE;
                mask_s  = 8'h00;
                fcnt_s  = 4'd0;
                pass_s  = 1'b0;
                ff_s    = 3'd0;
                ffv_s   = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            vec_r   <= 3'd0;
            cnt_r   <= 4'd0;
            drive_r <= 3'd0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            mask_r  <= 8'h00;
            fcnt_r  <= 4'd0;
            ff_r    <= 3'd0;
            ffv_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            vec_r   <= vec_s;
            cnt_r   <= cnt_s;
            drive_r <= drive_s;
            done_r  <= done_s;
            pass_r  <= pass_s;
            mask_r  <= mask_s;
            fcnt_r  <= fcnt_s;
            ff_r    <= ff_s;
            ffv_r   <= ffv_s;
        end
    end

    assign busy        = (state_r == SETTLE) || (state_r == SAMPLE);
    assign dut_a       = drive_r[2];
    assign dut_b       = drive_r[1];
    assign dut_c       = drive_r[0];
    assign done        = done_r;
    assign pass        = pass_r;
    assign result_mask = mask_r;
    assign fail_count  = fcnt_r;
`ifdef NOR3_TT_FIRSTFAIL_EN
    assign first_fail     = ff_r;
    assign first_fail_vld = ffv_r;
`else
    logic unused_ff_s;
    assign unused_ff_s = ^{ff_r, ffv_r};
`endif

endmodule

// File: tb/tb_nor3_tt_sequencer.sv
// Scoreboard bench for nor3_tt_sequencer: two instances (settle 2 and settle 1)
// driven through a shared stimulus path selected by sel.
module tb_nor3_tt_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_m, abort_m, sel;
    logic       start0, abort0, start1, abort1;
    logic       a0, b0, c0, y0, busy0, done0, pass0;
    logic       a1, b1, c1, y1, busy1, done1, pass1;
    logic [7:0] mask0, mask1;
    logic [3:0] fc0, fc1;
`ifdef NOR3_TT_FIRSTFAIL_EN
    logic [2:0] ff0, ff1;
    logic       ffv0, ffv1;
`endif
    int mode;
    int total = 0;
    int bad = 0;

    function automatic logic gate(input int m, input logic a, input logic b, input logic c);
        case (m)
            0:       return ~(a | b | c);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return a | b | c;
        endcase
    endfunction

    assign y0 = gate(mode, a0, b0, c0);
    assign y1 = gate(mode, a1, b1, c1);
    assign start0 = sel ? 1'b0 : start_m;
    assign abort0 = sel ? 1'b0 : abort_m;
    assign start1 = sel ? start_m : 1'b0;
    assign abort1 = sel ? abort_m : 1'b0;

    nor3_tt_sequencer #(.SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_y(y0),
        .busy(busy0), .done(done0), .pass(pass0),
        .result_mask(mask0), .fail_count(fc0)
`ifdef NOR3_TT_FIRSTFAIL_EN
        , .first_fail(ff0), .first_fail_vld(ffv0)
`endif
    );

    nor3_tt_sequencer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .result_mask(mask1), .fail_count(fc1)
`ifdef NOR3_TT_FIRSTFAIL_EN
        , .first_fail(ff1), .first_fail_vld(ffv1)
`endif
    );

    logic       m_busy, m_done, m_pass;
    logic [2:0] m_drv;
    logic [7:0] m_mask;
    logic [3:0] m_fc;
    always_comb begin
        m_busy = sel ? busy1 : busy0;
        m_done = sel ? done1 : done0;
        m_pass = sel ? pass1 : pass0;
        m_drv  = sel ? {a1, b1, c1} : {a0, b0, c0};
        m_mask = sel ? mask1 : mask0;
        m_fc   = sel ? fc1 : fc0;
    end

    typedef struct {
        logic [7:0] mask;
        logic [3:0] fc;
        logic       pass;
        logic [2:0] ff;
        logic       ffv;
    } res_t;
    res_t sbq[$];

    function automatic res_t model(input int m);
        res_t r;
        logic [2:0] vv;
        logic e, y;
        r.mask = 8'h00; r.fc = 4'd0; r.ff = 3'd0; r.ffv = 1'b0;
        for (int v = 0; v < 8; v++) begin
            vv = 3'(v);
            e = (v == 0);
            y = gate(m, vv[2], vv[1], vv[0]);
            r.mask[v] = (y == e);
            if (y != e) begin
                r.fc = r.fc + 4'd1;
                if (!r.ffv) begin
                    r.ff = vv;
                    r.ffv = 1'b1;
                end
            end
        end
        r.pass = (r.fc == 4'd0);
        return r;
    endfunction

    task automatic check_idle_clear(input string nm);
        total++;
        if (m_busy !== 1'b0 || m_drv !== 3'd0 || m_done !== 1'b0 ||
            m_mask !== 8'h00 || m_fc !== 4'd0 || m_pass !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%b drv=%b done=%b mask=%h fc=%0d pass=%b, required 0 0 0 00 0 0",
                     nm, m_busy, m_drv, m_done, m_mask, m_fc, m_pass);
        end
    endtask

    // Task is entered and left at a negedge; start is accepted at the next posedge.
    task automatic run(input int m, input int mid_start, input int tail);
        res_t ex;
        int s, lat;
        bit seen;
        s = sel ? 1 : 2;
        lat = 1 + 8 * (s + 1);
        mode = m;
        sbq.push_back(model(m));
        seen = 1'b0;
        start_m = 1'b1;
        for (int c = 1; c <= lat + tail; c++) begin
            @(negedge clk);
            start_m = (c == mid_start);
            total++;
            if (m_done !== (c == lat)) begin
                bad++;
                $display("FAIL done_timing: cycle %0d done=%b, required %b", c, m_done, (c == lat));
            end
            if (c == 1) begin
                total++;
                if (m_busy !== 1'b1 || m_mask !== 8'h00 || m_fc !== 4'd0 || m_pass !== 1'b0) begin
                    bad++;
                    $display("FAIL start_clear: busy=%b mask=%h fc=%0d pass=%b, required 1 00 0 0",
                             m_busy, m_mask, m_fc, m_pass);
                end
            end
            if (c < lat && ((c - 1) % (s + 1)) == 0) begin
                total++;
                if (m_drv !== 3'((c - 1) / (s + 1))) begin
                    bad++;
                    $display("FAIL drive: cycle %0d drv=%b, required %0d", c, m_drv, (c - 1) / (s + 1));
                end
            end
            if (m_done === 1'b1 && !seen && sbq.size() > 0) begin
                seen = 1'b1;
                ex = sbq.pop_front();
                total++;
                if (m_mask !== ex.mask || m_fc !== ex.fc || m_pass !== ex.pass || m_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL result: mask=%h fc=%0d pass=%b busy=%b, required %h %0d %b 0",
                             m_mask, m_fc, m_pass, m_busy, ex.mask, ex.fc, ex.pass);
                end
`ifdef NOR3_TT_FIRSTFAIL_EN
                total++;
                if ((sel ? ff1 : ff0) !== ex.ff || (sel ? ffv1 : ffv0) !== ex.ffv) begin
                    bad++;
                    $display("FAIL first_fail: ff=%0d vld=%b, required %0d %b",
                             sel ? ff1 : ff0, sel ? ffv1 : ffv0, ex.ff, ex.ffv);
                end
`endif
            end
        end
        start_m = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL no_done: done not seen within %0d cycles", lat + tail);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_m = 1'b0; abort_m = 1'b0; sel = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        check_idle_clear("reset_u0");
        sel = 1'b1;
        check_idle_clear("reset_u1");
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_patterns();
        sel = 1'b0;
        run(0, 0, 3);
        run(1, 0, 2);
        run(2, 0, 2);
        run(3, 0, 2);
    endtask

    task automatic test_mid_start();
        sel = 1'b0;
        run(0, 10, 2);
    endtask

    task automatic test_abort();
        sel = 1'b1;
        mode = 2;
        start_m = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start_m = 1'b0;
        end
        abort_m = 1'b1;
        @(negedge clk);
        abort_m = 1'b0;
        check_idle_clear("abort_vec3");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_done !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL abort_no_done: done=%b, required 0", m_done);
            end
        end
        run(0, 0, 1);
        sel = 1'b0;
    endtask

    task automatic test_start_abort_idle();
        sel = 1'b0;
        start_m = 1'b1;
        abort_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        abort_m = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (m_busy !== 1'b0 || m_drv !== 3'd0) begin
                bad++;
                $display("FAIL start_abort_idle: busy=%b drv=%b, required 0 000", m_busy, m_drv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        mode = 2;
        start_m = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start_m = 1'b0;
        end
        total++;
        if (m_drv !== 3'd5) begin
            bad++;
            $display("FAIL reset_mid_pre: drv=%b, required 101", m_drv);
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_clear("reset_mid");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run(2, 0, 1);
        run(0, 0, 0);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (m_busy !== 1'b0) begin
                bad++;
                $display("FAIL start_in_done: busy=%b, required 0", m_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_mid_start();
        test_abort();
        test_start_abort_idle();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
